// File: rtl/counter_pin_driver_if.sv
// Command port of counter_pin_driver.
//   cmd_valid : command present (host -> driver)
//   cmd_ready : driver idle, command taken on cmd_valid && cmd_ready
//   cmd_op    : 00 DISABLE, 01 ENABLE, 10 LOAD, 11 STEP
//   cmd_dir   : STEP direction, 1 up / 0 down
//   cmd_data  : LOAD value or STEP pulse count
interface counter_pin_driver_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dir;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_dir, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_dir, cmd_data, output cmd_ready);
endinterface

// File: rtl/counter_pin_driver.sv
// Host-side transmitter for the programmable counter pin interface.
// Turns single-cycle commands into slow pin waveforms whose levels are held
// long enough to cross the counter's 3-stage synchronizers, and tracks the
// value the counter is expected to hold (exp_count).
//   clk, rst        : clock, synchronous active-high reset
//   cmd             : command port (slave side of counter_pin_driver_if)
//   enable, clk_in, load, up_down, in : counter pins, all registered
//   done / err      : one-cycle pulse on completion / rejection
//   busy            : driver not idle
//   exp_count       : shadow of the counter value
module counter_pin_driver #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 4,
  parameter int SETUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  counter_pin_driver_if.slave cmd,
  output logic             enable,
  output logic             clk_in,
  output logic             load,
  output logic             up_down,
  output logic [WIDTH-1:0] in,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] exp_count
);

  localparam logic [1:0] OP_DIS  = 2'b00;
  localparam logic [1:0] OP_EN   = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam int TMAX = (SETUP > HOLD) ? SETUP : HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_SETUP = TW'(SETUP - 1);
  localparam logic [TW-1:0] T_HOLD  = TW'(HOLD - 1);

  logic [2:0]       state;
  logic [TW-1:0]    timer;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] remaining;

  assign cmd.cmd_ready = (state == S_IDLE) && !rst;
  assign busy          = !cmd.cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      op_q      <= OP_DIS;
      remaining <= '0;
      enable    <= 1'b0;
      clk_in    <= 1'b0;
      load      <= 1'b0;
      up_down   <= 1'b0;
      in        <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      exp_count <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            // LOAD/STEP on a disabled counter would be ignored by it; reject
            // so the shadow count never diverges.
            if (cmd.cmd_op[1] && !enable) begin
              err <= 1'b1;
            end else begin
              op_q  <= cmd.cmd_op;
              state <= S_SETUP;
              timer <= T_SETUP;
              case (cmd.cmd_op)
                OP_DIS:  enable <= 1'b0;
                OP_EN:   enable <= 1'b1;
                OP_LOAD: in <= cmd.cmd_data;
                default: begin
                  up_down   <= cmd.cmd_dir;
                  remaining <= cmd.cmd_data;
                end
              endcase
            end
          end
        end
        S_SETUP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (op_q == OP_LOAD) begin
            state <= S_HI;
            timer <= T_HOLD;
            load  <= 1'b1;
          end else if (op_q == OP_STEP && remaining != '0) begin
            state  <= S_HI;
            timer  <= T_HOLD;
            clk_in <= 1'b1;
          end else begin
            state <= S_FIN;
            done  <= 1'b1;
          end
        end
        S_HI: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state  <= S_LO;
            timer  <= T_HOLD;
            load   <= 1'b0;
            clk_in <= 1'b0;
          end
        end
        S_LO: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (op_q == OP_LOAD) begin
            exp_count <= in;
            state     <= S_FIN;
            done      <= 1'b1;
          end else begin
            // One full clk_in pulse has been seen by the counter.
            exp_count <= up_down ? exp_count + 1'b1 : exp_count - 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == WIDTH'(1)) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state  <= S_HI;
              timer  <= T_HOLD;
              clk_in <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/counter_pin_driver.md
Name: counter_pin_driver

Overview:
- Host-side transmitter for the programmable counter's pin interface (enable, clk_in, load, up_down, in).
- Converts single-cycle commands on a valid/ready port into slow, glitch-free pin waveforms. Each level is held long enough to pass the counter's 3-stage input synchronizers and edge detectors.
- Keeps a shadow model of the expected counter value for self-checking top-levels and benches.

Parameters:
WIDTH, 8, width of in bus, step count and shadow count
HOLD, 4, cycles each load/clk_in level is held high and low (legal ≥3)
SETUP, 4, cycles data/direction/enable are stable before first pulse edge (legal ≥3)

Ports:
clk  input  1  system clock, same domain as counter
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
cmd_op  input  2  00 DISABLE, 01 ENABLE, 10 LOAD, 11 STEP
cmd_dir  input  1  STEP direction: 1 up, 0 down
cmd_data  input  WIDTH  LOAD value or STEP pulse count
enable  output  1  to counter enable pin
clk_in  output  1  to counter clk_in pin
load  output  1  to counter load pin
up_down  output  1  to counter up_down pin
in  output  WIDTH  to counter in bus
done  output  1  one-cycle pulse when a command completes
err  output  1  one-cycle pulse when a command is rejected
busy  output  1  high while not IDLE
exp_count  output  WIDTH  shadow of expected counter value

Behaviour:
- All outputs are registered. Acceptance edge = T; new pin values are visible from cycle T+1.
- Reset (rst high at an edge): all outputs 0, cmd_ready 1, state IDLE, timers 0.
  - Reset mid-command aborts it. Pins return to 0 on the next edge. No done, no err.
- FSM states:
  - IDLE
  - SETUP_WAIT: SETUP cycles
  - PULSE_HI: HOLD cycles
  - PULSE_LO: HOLD cycles
  - FINISH: 1 cycle; done=1, back to IDLE
- cmd_ready = (state == IDLE) && !rst. busy = !cmd_ready.
- ENABLE: enable←1 at T. SETUP_WAIT → FINISH. Total latency T+1 .. done at cycle T+SETUP+1.
- DISABLE: enable←0 at T. SETUP_WAIT → FINISH. Same latency as ENABLE.
- LOAD or STEP with enable==0:
  - Rejected: err=1 in cycle T+1, stays IDLE.
  - No pin change, exp_count unchanged.
- LOAD:
  - At T: in←cmd_data. SETUP_WAIT, then PULSE_HI with load=1, then PULSE_LO with load=0, then FINISH.
  - exp_count←cmd_data on the PULSE_LO→FINISH edge.
  - in holds its value after completion until the next LOAD; the counter samples in unsynchronized, so in never changes while load can be seen high.
  - done at T+SETUP+2·HOLD+1.
- STEP:
  - At T: up_down←cmd_dir, remaining←cmd_data. SETUP_WAIT.
  - If remaining==0: go to FINISH, no pulses.
  - Else loop: PULSE_HI (clk_in=1), PULSE_LO (clk_in=0).
  - At the end of each PULSE_LO: exp_count ±1 modulo 2^WIDTH (255+1→0, 0−1→255), remaining−1. Loop while remaining≠0.
  - up_down is held for the whole command and after it.
  - done at T+SETUP+N·2·HOLD+1.
- Invariants:
  - Never more than one of load/clk_in high.
  - Neither is high while enable is 0.
  - Every high and low level of load/clk_in lasts exactly HOLD cycles.
- cmd_* is ignored when not ready. The command is latched at acceptance, so later cmd_* changes have no effect.
- exp_count reset value 0 matches the counter's reset value.

Test Plan (HOLD=4, SETUP=4, WIDTH=8):
1. Reset, then ENABLE at T → enable=1 from T+1, done at T+5, cmd_ready=0 during T+1..T+5, exp_count=0.
2. LOAD 0xA5 after ENABLE → in=0xA5 from T+1; load high exactly cycles T+5..T+8; done at T+13, exp_count=0xA5. With the counter instantiated, counter_reg=0xA5.
3. LOAD 0xFE, then STEP up N=3 → 3 clk_in pulses of 4 high / 4 low; exp_count FE→FF→00→01; done at T+29. Counter matches 0x01.
4. STEP down N=2 from exp_count 0x01 → 0x00, 0xFF; STEP N=0 → no clk_in activity, done at T+5.
5. DISABLE, then LOAD 0x33 → err pulse at T+1, load/in unchanged, exp_count unchanged, no done.
6. rst asserted during the second STEP pulse → all pins 0 next cycle, exp_count=0, cmd_ready=1; a following ENABLE completes normally.
